// File: rtl/sw_seq_writer_pkg.sv
// Shared constants and FSM encoding for the Smith-Waterman SRAM sequence writer.
package sw_seq_writer_pkg;
  localparam int SYM_BIT         = 2;
  localparam int SW_WDOG         = 4;
  localparam int SRAM_WORD_WIDTH = 8;
  localparam int SRAM_ADDR_BIT   = 4;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_FLUSH, ST_HDR, ST_START, ST_WAIT_HI, ST_WAIT_LO, ST_DONE
  } sw_state_e;
endpackage

// File: rtl/sw_sym_packer.sv
// Packs 2-bit symbols LSB-first into SRAM words; emits a registered word when full or on flush.
module sw_sym_packer
  import sw_seq_writer_pkg::*;
#(
  parameter int WORD_W = SRAM_WORD_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push,
  input  logic [SYM_BIT-1:0] i_sym,
  input  logic               i_flush,
  output logic               o_vld,
  output logic [WORD_W-1:0]  o_word
);
  localparam int SPW   = WORD_W / SYM_BIT;
  localparam int CNT_W = $clog2(SPW);

  logic [WORD_W-1:0] r_buf, r_word, w_nbuf;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_vld;

  always_comb begin
    w_nbuf = r_buf;
    w_nbuf[int'(r_cnt)*SYM_BIT +: SYM_BIT] = i_sym;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_buf  <= '0;
      r_word <= '0;
      r_cnt  <= '0;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      if (i_push) begin
        if (r_cnt == CNT_W'(SPW-1)) begin
          r_word <= w_nbuf;
          r_vld  <= 1'b1;
          r_buf  <= '0;
          r_cnt  <= '0;
        end else begin
          r_buf <= w_nbuf;
          r_cnt <= r_cnt + 1'b1;
        end
      end else if (i_flush && r_cnt != '0) begin
        // unused upper symbol slots are already zero
        r_word <= r_buf;
        r_vld  <= 1'b1;
        r_buf  <= '0;
        r_cnt  <= '0;
      end
    end
  end

  assign o_vld  = r_vld;
  assign o_word = r_word;
endmodule

// File: rtl/sw_seq_writer.sv
// Host-side writer: loads T/Q banks with packed symbols plus a length header, then runs the engine.
module sw_seq_writer
  import sw_seq_writer_pkg::*;
#(
  parameter int WORD_W = SRAM_WORD_WIDTH,
  parameter int ADDR_W = SRAM_ADDR_BIT,
  parameter int WDOG   = SW_WDOG,
  parameter int LEN_W  = ADDR_W + $clog2(WORD_W/SYM_BIT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  input  logic [SYM_BIT-1:0] s_sym_i,
  input  logic               s_last_i,
  input  logic               s_sel_T_i,
  input  logic               go_i,
  output logic               wr_en_o,
  output logic               wr_sel_T_o,
  output logic [ADDR_W-1:0]  wr_addr_o,
  output logic [WORD_W-1:0]  wr_data_o,
  output logic               sw_start_o,
  input  logic               sw_busy_i,
  output logic [LEN_W-1:0]   t_len_o,
  output logic [LEN_W-1:0]   q_len_o,
  output logic               done_o,
  output logic               err_o
);
  localparam int              SPW  = WORD_W / SYM_BIT;
  localparam logic [LEN_W-1:0] CAP = LEN_W'(((1 << ADDR_W) - 1) * SPW);
  localparam int              WD_W = $clog2(WDOG + 1);

  sw_state_e         r_state;
  logic              r_ready, r_sel, r_start, r_done, r_err, r_hdr_wr;
  logic              r_t_loaded, r_q_loaded;
  logic [LEN_W-1:0]  r_cnt, r_t_len, r_q_len;
  logic [ADDR_W-1:0] r_waddr;
  logic [WORD_W-1:0] r_hdr_data;
  logic [WD_W-1:0]   r_wd;

  logic              w_acc, w_push, w_pk_vld;
  logic [WORD_W-1:0] w_pk_word;

  assign w_acc  = s_valid_i & r_ready;
  // the first symbol of a sequence always fits; later ones only below capacity
  assign w_push = w_acc & ((r_state == ST_IDLE) | (r_cnt != CAP));

  sw_sym_packer #(.WORD_W(WORD_W)) u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_sym   (s_sym_i),
    .i_flush (r_state == ST_FLUSH),
    .o_vld   (w_pk_vld),
    .o_word  (w_pk_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ready    <= 1'b0;
      r_sel      <= 1'b0;
      r_start    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_hdr_wr   <= 1'b0;
      r_t_loaded <= 1'b0;
      r_q_loaded <= 1'b0;
      r_cnt      <= '0;
      r_t_len    <= '0;
      r_q_len    <= '0;
      r_waddr    <= '0;
      r_hdr_data <= '0;
      r_wd       <= '0;
    end else begin
      r_start  <= 1'b0;
      r_done   <= 1'b0;
      r_hdr_wr <= 1'b0;
      if (w_pk_vld) r_waddr <= r_waddr + 1'b1;
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (w_acc) begin
            r_sel   <= s_sel_T_i;
            r_waddr <= ADDR_W'(1);
            r_cnt   <= LEN_W'(1);
            if (s_sel_T_i) begin
              r_t_loaded <= 1'b0;
              r_t_len    <= '0;
            end else begin
              r_q_loaded <= 1'b0;
              r_q_len    <= '0;
            end
            if (s_last_i) begin
              r_state <= ST_FLUSH;
              r_ready <= 1'b0;
            end else begin
              r_state <= ST_LOAD;
            end
          end else if (!s_valid_i && go_i) begin
            if (r_t_loaded && r_q_loaded) begin
              r_err   <= 1'b0;
              r_start <= 1'b1;
              r_ready <= 1'b0;
              r_state <= ST_START;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (w_acc) begin
            if (r_cnt != CAP) r_cnt <= r_cnt + 1'b1;
            else              r_err <= 1'b1;
            if (s_last_i) begin
              r_state <= ST_FLUSH;
              r_ready <= 1'b0;
            end
          end
        end
        ST_FLUSH: r_state <= ST_HDR;
        ST_HDR: begin
          // header lands one cycle later, after any partial-word write has drained
          r_hdr_wr   <= 1'b1;
          r_hdr_data <= WORD_W'(r_cnt);
          if (r_sel) begin
            r_t_loaded <= 1'b1;
            r_t_len    <= r_cnt;
          end else begin
            r_q_loaded <= 1'b1;
            r_q_len    <= r_cnt;
          end
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        ST_START: begin
          r_wd    <= '0;
          r_state <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (sw_busy_i) begin
            r_state <= ST_WAIT_LO;
          end else if (r_wd == WD_W'(WDOG-1)) begin
            r_err   <= 1'b1;
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        ST_WAIT_LO: begin
          if (!sw_busy_i) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_ready_o  = r_ready;
  assign wr_en_o    = w_pk_vld | r_hdr_wr;
  assign wr_sel_T_o = r_sel;
  assign wr_addr_o  = w_pk_vld ? r_waddr : '0;
  assign wr_data_o  = r_hdr_wr ? r_hdr_data : (w_pk_vld ? w_pk_word : '0);
  assign sw_start_o = r_start;
  assign done_o     = r_done;
  assign err_o      = r_err;
  assign t_len_o    = r_t_len;
  assign q_len_o    = r_q_len;
endmodule

// File: tb/tb_sw_seq_writer.sv
// Directed bench for sw_seq_writer: bank loads, overflow, engine handshake, watchdog and reset.
module tb_sw_seq_writer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid_i, s_ready_o, s_last_i, s_sel_T_i, go_i;
  logic [1:0]  s_sym_i;
  logic        wr_en_o, wr_sel_T_o, sw_start_o, sw_busy_i, done_o, err_o;
  logic [3:0]  wr_addr_o;
  logic [7:0]  wr_data_o;
  logic [5:0]  t_len_o, q_len_o;

  int          n_vec = 0, n_err = 0;
  int          cyc = 0, start_cnt = 0, done_cnt = 0, done_cyc = 0, busy_fall_cyc = 0;
  int          ready_drops = 0;
  logic [12:0] wq[$];
  logic [1:0]  r_syms[0:63];

  sw_seq_writer #(.WORD_W(8), .ADDR_W(4), .WDOG(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_sym_i(s_sym_i),
    .s_last_i(s_last_i), .s_sel_T_i(s_sel_T_i), .go_i(go_i),
    .wr_en_o(wr_en_o), .wr_sel_T_o(wr_sel_T_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .sw_start_o(sw_start_o), .sw_busy_i(sw_busy_i),
    .t_len_o(t_len_o), .q_len_o(q_len_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en_o) wq.push_back({wr_sel_T_o, wr_addr_o, wr_data_o});
    if (sw_start_o) start_cnt++;
    if (done_o) begin done_cnt++; done_cyc = cyc; end
    if (rst_n && s_valid_i && !s_ready_o) ready_drops++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_seq(input bit sel, input int n);
    for (int i = 0; i < n; i++) begin
      s_valid_i = 1'b1; s_sym_i = r_syms[i]; s_last_i = (i == n-1); s_sel_T_i = sel;
      tick(1);
    end
    s_valid_i = 1'b0; s_last_i = 1'b0;
    tick(6);
  endtask

  task automatic pulse_go();
    go_i = 1'b1;
    tick(1);
    go_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
  endtask

  initial begin
    rst_n = 1'b0; s_valid_i = 0; s_sym_i = 0; s_last_i = 0; s_sel_T_i = 0; go_i = 0; sw_busy_i = 0;
    tick(3);
    chk("rst_out", {wr_en_o, s_ready_o, sw_start_o, done_o, err_o, wr_addr_o, wr_data_o}, 0);
    chk("rst_len", {t_len_o, q_len_o}, 0);
    rst_n = 1'b1;
    tick(3);

    // 1: T bank, 6 symbols, one full and one partial word
    wq.delete();
    r_syms[0] = 0; r_syms[1] = 1; r_syms[2] = 2; r_syms[3] = 3; r_syms[4] = 0; r_syms[5] = 1;
    send_seq(1'b1, 6);
    chk("t1_nwr", wq.size(), 3);
    chk("t1_w0", wq[0], {1'b1, 4'd1, 8'hE4});
    chk("t1_w1", wq[1], {1'b1, 4'd2, 8'h04});
    chk("t1_hdr", wq[2], {1'b1, 4'd0, 8'h06});
    chk("t1_len", t_len_o, 6);

    // 2: Q bank, exact word, no partial write
    wq.delete();
    for (int i = 0; i < 4; i++) r_syms[i] = 2'd3;
    send_seq(1'b0, 4);
    chk("t2_nwr", wq.size(), 2);
    chk("t2_w0", wq[0], {1'b0, 4'd1, 8'hFF});
    chk("t2_hdr", wq[1], {1'b0, 4'd0, 8'h04});
    chk("t2_len", q_len_o, 4);
    chk("t2_err", err_o, 0);

    // 3: T overflow, 61 symbols into a 60-symbol bank
    wq.delete();
    for (int i = 0; i < 61; i++) r_syms[i] = 2'(i % 4);
    send_seq(1'b1, 61);
    chk("t3_nwr", wq.size(), 16);
    chk("t3_first", wq[0], {1'b1, 4'd1, 8'hE4});
    chk("t3_last", wq[14], {1'b1, 4'd15, 8'hE4});
    chk("t3_hdr", wq[15], {1'b1, 4'd0, 8'h3C});
    chk("t3_err", err_o, 1);
    chk("t3_len", t_len_o, 60);
    chk("t3_ready", ready_drops, 0);

    // 4: engine run, busy rises 2 cycles after start and holds 10
    start_cnt = 0; done_cnt = 0; wq.delete();
    pulse_go();
    tick(2);
    sw_busy_i = 1'b1;
    tick(10);
    sw_busy_i = 1'b0; busy_fall_cyc = cyc;
    tick(5);
    chk("t4_start", start_cnt, 1);
    chk("t4_done", done_cnt, 1);
    chk("t4_done_lat", done_cyc - busy_fall_cyc, 1);
    chk("t4_err", err_o, 0);
    chk("t4_nowr", wq.size(), 0);
    chk("t4_ready", s_ready_o, 1);

    // 5: go with only T loaded, then watchdog with busy held low
    do_reset();
    for (int i = 0; i < 4; i++) r_syms[i] = 2'(i);
    send_seq(1'b1, 4);
    start_cnt = 0;
    pulse_go();
    tick(2);
    chk("t5_err_noq", err_o, 1);
    chk("t5_nostart", start_cnt, 0);
    send_seq(1'b0, 4);
    pulse_go();
    tick(2);
    chk("t5_err_clr", err_o, 0);
    chk("t5_start", start_cnt, 1);
    tick(3);
    chk("t5_wdog", err_o, 1);
    chk("t5_ready", s_ready_o, 1);

    // 6: reset in the middle of a T load
    for (int i = 0; i < 3; i++) begin
      s_valid_i = 1'b1; s_sym_i = 2'(i); s_last_i = 1'b0; s_sel_T_i = 1'b1;
      tick(1);
    end
    s_valid_i = 1'b0;
    rst_n = 1'b0;
    tick(1);
    chk("t6_rst_out", {wr_en_o, s_ready_o, sw_start_o, done_o, err_o}, 0);
    chk("t6_rst_len", {t_len_o, q_len_o}, 0);
    rst_n = 1'b1;
    tick(2);
    start_cnt = 0;
    pulse_go();
    tick(2);
    chk("t6_err", err_o, 1);
    chk("t6_nostart", start_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
